// File: rtl/rx_core_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_core_if
// Brief    : ADC sample stream in, packed I/Q result stream out (valid/ready).
// Revision : 1.0
// ============================================================================
interface rx_core_if #(
  parameter int NUMBER_OF_LINE = 8
);
  logic [16*NUMBER_OF_LINE-1:0] adc_data;
  logic                         adc_valid;
  logic [31:0]                  iq_data;
  logic                         iq_valid;
  logic                         iq_ready;

  modport master (
    output adc_data, adc_valid, iq_ready,
    input  iq_data, iq_valid
  );

  modport slave (
    input  adc_data, adc_valid, iq_ready,
    output iq_data, iq_valid
  );
endinterface
`default_nettype wire

// File: rtl/rx_core.sv
`default_nettype none
// ============================================================================
// Module   : rx_core
// Brief    : 8-lane NCO downmix, lane sum, integrate-and-dump, I/Q handshake.
// Revision : 1.0
// ============================================================================
module rx_core #(
  parameter int NUMBER_OF_LINE = 8
) (
  input  wire logic        clock,
  input  wire logic        resetn,
  rx_core_if.slave         stream,
  input  wire logic [15:0] lo_dds_phase_inc,
  input  wire logic [3:0]  decim_log2,
  input  wire logic        clear_overflow,
  output logic             overflow
);

  localparam int c_pairs = NUMBER_OF_LINE / 2;

  // First quarter of round(32767*sin(2*pi*k/256)), k = 0..64
  localparam logic signed [15:0] c_quarter [0:64] = '{
    16'd0,     16'd804,   16'd1608,  16'd2410,  16'd3212,  16'd4011,  16'd4808,  16'd5602,
    16'd6393,  16'd7179,  16'd7962,  16'd8739,  16'd9512,  16'd10278, 16'd11039, 16'd11793,
    16'd12539, 16'd13279, 16'd14010, 16'd14732, 16'd15446, 16'd16151, 16'd16846, 16'd17530,
    16'd18204, 16'd18868, 16'd19519, 16'd20159, 16'd20787, 16'd21403, 16'd22005, 16'd22594,
    16'd23170, 16'd23731, 16'd24279, 16'd24811, 16'd25329, 16'd25832, 16'd26319, 16'd26790,
    16'd27245, 16'd27683, 16'd28105, 16'd28510, 16'd28898, 16'd29268, 16'd29621, 16'd29956,
    16'd30273, 16'd30571, 16'd30852, 16'd31113, 16'd31356, 16'd31580, 16'd31785, 16'd31971,
    16'd32137, 16'd32285, 16'd32412, 16'd32521, 16'd32609, 16'd32678, 16'd32728, 16'd32757,
    16'd32767
  };

  // Quarter-wave symmetry rebuilds the full 256-entry sine table
  function automatic logic signed [15:0] rom_lookup(input logic [7:0] k);
    logic [6:0]         idx;
    logic signed [15:0] mag;
    idx = k[6] ? (7'd64 - {1'b0, k[5:0]}) : {1'b0, k[5:0]};
    mag = c_quarter[idx];
    return k[7] ? -mag : mag;
  endfunction

  logic [15:0]        r_acc;
  logic               r_v0, r_v1, r_v2, r_v3, r_v4;
  logic [7:0]         r_k0   [NUMBER_OF_LINE];
  logic signed [15:0] r_d0   [NUMBER_OF_LINE];
  logic signed [15:0] r_d1   [NUMBER_OF_LINE];
  logic signed [15:0] r_sin1 [NUMBER_OF_LINE];
  logic signed [15:0] r_cos1 [NUMBER_OF_LINE];
  logic signed [15:0] r_i2   [NUMBER_OF_LINE];
  logic signed [15:0] r_q2   [NUMBER_OF_LINE];
  logic signed [16:0] r_pi3  [c_pairs];
  logic signed [16:0] r_pq3  [c_pairs];
  logic signed [18:0] r_si4, r_sq4;
  logic signed [18:0] w_si, w_sq;

  logic [3:0]         r_d;
  logic [9:0]         r_cnt;
  logic signed [29:0] r_acc_i, r_acc_q;
  logic [3:0]         w_dlat, w_d_eff;
  logic [9:0]         w_last;
  logic [4:0]         w_shift;
  logic               w_dump, w_ovf_evt;
  logic signed [29:0] w_sum_i, w_sum_q;
  logic [31:0]        w_res;

  // NCO accumulator and valid bits travelling alongside the data
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_acc <= '0;
      r_v0  <= 1'b0;
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_v4  <= 1'b0;
    end else begin
      r_v0 <= stream.adc_valid;
      r_v1 <= r_v0;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      r_v4 <= r_v3;
      if (stream.adc_valid)
        r_acc <= r_acc + {lo_dds_phase_inc[12:0], 3'b000};
    end
  end

  // Datapath E0..E4; only the valid bits need reset
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUMBER_OF_LINE; i++) begin
      r_d0[i]   <= stream.adc_data[16*i +: 16];
      r_k0[i]   <= 8'((r_acc + 16'(i * int'(lo_dds_phase_inc))) >> 8);
      r_d1[i]   <= r_d0[i];
      r_sin1[i] <= rom_lookup(r_k0[i]);
      r_cos1[i] <= rom_lookup(r_k0[i] + 8'd64);
      r_i2[i]   <= 16'((32'(r_d1[i]) * 32'(r_cos1[i])) >>> 15);
      r_q2[i]   <= 16'((32'(r_d1[i]) * 32'(r_sin1[i])) >>> 15);
    end
    for (int j = 0; j < c_pairs; j++) begin
      r_pi3[j] <= 17'(r_i2[2*j]) + 17'(r_i2[2*j+1]);
      r_pq3[j] <= 17'(r_q2[2*j]) + 17'(r_q2[2*j+1]);
    end
    r_si4 <= w_si;
    r_sq4 <= w_sq;
  end

  always_comb begin
    w_si = '0;
    w_sq = '0;
    for (int j = 0; j < c_pairs; j++) begin
      w_si = w_si + 19'(r_pi3[j]);
      w_sq = w_sq + 19'(r_pq3[j]);
    end
  end

  // A new block picks up decim_log2 on its first sample
  always_comb begin
    w_dlat    = (decim_log2 > 4'd10) ? 4'd10 : decim_log2;
    w_d_eff   = (r_cnt == 10'd0) ? w_dlat : r_d;
    w_last    = 10'((11'd1 << w_d_eff) - 11'd1);
    w_dump    = r_v4 && (r_cnt == w_last);
    w_sum_i   = r_acc_i + 30'(r_si4);
    w_sum_q   = r_acc_q + 30'(r_sq4);
    w_shift   = 5'd3 + {1'b0, w_d_eff};
    w_res     = {16'(w_sum_q >>> w_shift), 16'(w_sum_i >>> w_shift)};
    w_ovf_evt = w_dump && stream.iq_valid && !stream.iq_ready;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_d             <= '0;
      r_cnt           <= '0;
      r_acc_i         <= '0;
      r_acc_q         <= '0;
      stream.iq_data  <= '0;
      stream.iq_valid <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      if (r_v4) begin
        if (r_cnt == 10'd0)
          r_d <= w_dlat;
        if (w_dump) begin
          r_acc_i <= '0;
          r_acc_q <= '0;
          r_cnt   <= '0;
        end else begin
          r_acc_i <= w_sum_i;
          r_acc_q <= w_sum_q;
          r_cnt   <= r_cnt + 10'd1;
        end
      end
      // An unconsumed word is never overwritten; the new result is dropped
      if (w_dump) begin
        if (!stream.iq_valid || stream.iq_ready) begin
          stream.iq_data  <= w_res;
          stream.iq_valid <= 1'b1;
        end
      end else if (stream.iq_ready) begin
        stream.iq_valid <= 1'b0;
      end
      if (w_ovf_evt)
        overflow <= 1'b1;
      else if (clear_overflow)
        overflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/rx_core.md
# rx_core

Receive-side counterpart of the transmit datapath. Takes NUMBER_OF_LINE parallel 16-bit ADC samples per clock and mixes each lane with an internal NCO cosine/sine to produce I/Q. It sums the lanes, then applies integrate-and-dump decimation by 2^decim_log2 clocks. The result is delivered as one packed I/Q word over a valid/ready handshake, with a sticky overflow flag.

## Interface
- NUMBER_OF_LINE, 8: samples per clock; must be 8 (lane-sum scaling is fixed at 1/8).
- clock  in  1: single clock; all logic is posedge.
- resetn  in  1: asynchronous, active-low reset.
- adc_data  in  16*NUMBER_OF_LINE: lane i = bits [16*(i+1)-1:16*i], signed two's complement; lane 0 is the earliest sample in time.
- adc_valid  in  1: adc_data is valid this clock.
- lo_dds_phase_inc  in  16: NCO phase step per sample.
- decim_log2  in  4: dump length is 2^decim_log2 valid clocks; values above 10 are treated as 10.
- iq_data  out  32: {Q[15:0], I[15:0]}, both signed.
- iq_valid  out  1: iq_data holds an unconsumed result.
- iq_ready  in  1: consumer accepts iq_data when iq_valid && iq_ready.
- overflow  out  1: sticky; a result was dropped because of backpressure.
- clear_overflow  in  1: synchronous clear of overflow.

## Operation
- **NCO**
  - 16-bit phase accumulator acc, reset 0.
  - On each adc_valid clock: acc <= acc + 8*lo_dds_phase_inc, modulo 2^16.
  - Lane i phase = acc(pre-update) + i*lo_dds_phase_inc, modulo 2^16.
  - acc holds when adc_valid = 0.
- **ROM**
  - 256-entry signed 16-bit table; ROM[k] = round(32767*sin(2πk/256)).
  - k = phase[15:8]; sin = ROM[k]; cos = ROM[(k+64) mod 256].
  - Entries lie within ±32767.
- **Mixer**
  - I_i = (adc_i*cos)[30:15]; Q_i = (adc_i*sin)[30:15].
  - The product is 32-bit signed; taking bits [30:15] is an arithmetic floor.
  - No overflow is possible because |ROM| ≤ 32767.
- **Lane sum**
  - SI = ΣI_i, SQ = ΣQ_i, each 19-bit signed.
- **Integrator**
  - 30-bit signed accumulators accI/accQ and a 10-bit counter cnt.
  - Only valid samples (a valid bit travels down the pipeline) are accumulated.
  - decim_log2 is latched into D when a valid sample enters with cnt = 0.
  - On a valid sample with cnt = 2^D − 1 (dump):
    - result I = (accI + SI) >>> (3+D), truncated to 16 bits; Q likewise.
    - accI/accQ <= 0; cnt <= 0.
  - Otherwise: accI/accQ accumulate and cnt increments.
- **Output register**
  - Priority order:
    - Dump while iq_valid = 0, or while iq_valid && iq_ready: load the result; iq_valid = 1.
    - Dump while iq_valid && !iq_ready: discard the result, hold iq_data, set overflow.
    - iq_ready with no dump: iq_valid <= 0.
  - If clear_overflow and a new overflow event occur in the same cycle, overflow stays 1.
- **Reset** (async assert, at any time including mid-block): acc, cnt, accumulators, pipeline valids, iq_data, iq_valid and overflow all go to 0. The partial block is lost.

## Timing
- Pipeline registers: E0 input/phase, E1 ROM read, E2 product, E3 slice, E4 lane sum, E5 integrator/output register.
- With decim_log2 = 0, a sample taken at edge n drives iq_valid/iq_data after edge n+5.
- With D > 0, iq_valid rises after edge n+5, where n is the edge of the 2^D-th valid sample of the block.
- Throughput: one result per 2^D valid clocks; with D = 0 and iq_ready held high, one result every clock.
- After reset, outputs are iq_data = 0, iq_valid = 0, overflow = 0. No result appears before the first adc_valid plus 6 edges.
- Changes to lo_dds_phase_inc take effect on the next valid sample. Changes to decim_log2 take effect only at the next block start.

## Test plan
1. **Reset:** assert resetn = 0 mid-stream -> iq_valid = 0, iq_data = 0, overflow = 0 immediately. First result appears exactly 6 edges after the first post-reset valid sample (D = 0).
2. **DC, zero phase step:** inc = 0, D = 0, all lanes 16384, iq_ready = 1 -> every clock iq_data = {Q = 0, I = 16383}; latency 6 edges.
3. **fs/8 LO:** inc = 0x2000, D = 0, all lanes 16384 -> I = −1, Q = −1 each clock. acc wraps to 0 every clock.
4. **Decimation with gaps:** inc = 0, D = 3, all lanes 1000, adc_valid toggling 1/0 -> one result per 8 valid samples, I = 999, Q = 0. acc and cnt frozen on invalid clocks.
5. **Backpressure:** D = 0, iq_ready = 0, inputs 1000 then 2000 -> iq_data holds I = 999, overflow = 1 on the second dump. Raising iq_ready for one clock with no dump drops iq_valid. clear_overflow -> 0.
6. **decim_log2 change mid-block:** D = 2 block in progress, switch input to 4 -> current block completes after 4 valid samples; next block uses 16. Input 11 -> blocks of 1024.
